// File: rtl/psd_pkg.sv
// psd shared types: FSM states, error codes and tag bit position.
// Imported by psd and psd_sat_cnt.
package psd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PKT  = 2'd1,
    DROP = 2'd2
  } psd_state_t;

  localparam logic [1:0] ERR_STRAY   = 2'd1;
  localparam logic [1:0] ERR_OVERLEN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  localparam int TAG_BIT = 8;

endpackage

// File: rtl/psd_sat_cnt.sv
// 16-bit saturating event counter; sticks at 0xFFFF.
// Ports: i_clk, i_rst (async high), i_inc, ov_cnt.
module psd_sat_cnt
  import psd_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inc,
  output logic [15:0] ov_cnt
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ov_cnt = cnt_q;

endmodule

// File: rtl/psd.sv
// psd: tagged 9-bit stream decoder with framing, length and idle checks.
// In: iv_data/i_data_wr. Out: ov_data, o_data_wr, o_sop, o_eop, ov_len,
// o_err, ov_err_code, ov_pkt_cnt, ov_err_cnt. All outputs registered.
module psd
  import psd_pkg::*;
#(
  parameter int P_MAX_LEN = 1518,
  parameter int P_TIMEOUT = 256
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [8:0]  iv_data,
  input  logic        i_data_wr,
  output logic [7:0]  ov_data,
  output logic        o_data_wr,
  output logic        o_sop,
  output logic        o_eop,
  output logic [11:0] ov_len,
  output logic        o_err,
  output logic [1:0]  ov_err_code,
  output logic [15:0] ov_pkt_cnt,
  output logic [15:0] ov_err_cnt
);

  localparam logic [12:0] MAX_LEN = 13'(P_MAX_LEN);
  localparam logic [15:0] TO_LAST = 16'(P_TIMEOUT - 1);

  psd_state_t  state_q, state_d;
  logic [11:0] len_q, len_d;
  logic [15:0] idle_q, idle_d;
  logic [7:0]  data_q, data_d;
  logic        dwr_q, dwr_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;
  logic [11:0] olen_q, olen_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        tag;
  logic [12:0] len_inc;

  assign tag     = iv_data[TAG_BIT];
  assign len_inc = {1'b0, len_q} + 13'd1;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idle_d  = idle_q;
    data_d  = data_q;
    dwr_d   = 1'b0;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    olen_d  = olen_q;
    err_d   = 1'b0;
    code_d  = code_q;
    if (i_data_wr) begin
      // any write restarts the gap timer, even one that also ends the packet
      idle_d = '0;
      case (state_q)
        IDLE: begin
          if (tag) begin
            dwr_d   = 1'b1;
            sop_d   = 1'b1;
            data_d  = iv_data[7:0];
            len_d   = 12'd1;
            state_d = PKT;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_STRAY;
          end
        end
        PKT: begin
          if (!tag) begin
            // leave room for the tail within the limit
            if (len_inc < MAX_LEN) begin
              dwr_d  = 1'b1;
              data_d = iv_data[7:0];
              len_d  = len_inc[11:0];
            end else begin
              err_d   = 1'b1;
              code_d  = ERR_OVERLEN;
              state_d = DROP;
            end
          end else if (len_inc > MAX_LEN) begin
            err_d   = 1'b1;
            code_d  = ERR_OVERLEN;
            state_d = IDLE;
          end else begin
            dwr_d   = 1'b1;
            eop_d   = 1'b1;
            data_d  = iv_data[7:0];
            olen_d  = len_inc[11:0];
            state_d = IDLE;
          end
        end
        DROP: begin
          if (tag) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (idle_q == TO_LAST) begin
        idle_d  = '0;
        state_d = IDLE;
        // a packet already being dropped was reported once; exit quietly
        if (state_q == PKT) begin
          err_d  = 1'b1;
          code_d = ERR_TIMEOUT;
        end
      end else begin
        idle_d = idle_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      idle_q  <= '0;
      data_q  <= '0;
      dwr_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      olen_q  <= '0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idle_q  <= idle_d;
      data_q  <= data_d;
      dwr_q   <= dwr_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      olen_q  <= olen_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // counters take the next-state events so they move with o_eop / o_err
  psd_sat_cnt u_pkt_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (eop_d),
    .ov_cnt (ov_pkt_cnt)
  );

  psd_sat_cnt u_err_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (err_d),
    .ov_cnt (ov_err_cnt)
  );

  assign ov_data     = data_q;
  assign o_data_wr   = dwr_q;
  assign o_sop       = sop_q;
  assign o_eop       = eop_q;
  assign ov_len      = olen_q;
  assign o_err       = err_q;
  assign ov_err_code = code_q;

endmodule

// File: tb/tb_psd.sv
// tb_psd: random and directed stimulus for psd checked against a
// packet-level reference model.
module tb_psd;

  localparam int MAXL = 4;
  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  iv_data = '0;
  logic        i_data_wr = 1'b0;
  logic [7:0]  ov_data;
  logic        o_data_wr, o_sop, o_eop, o_err;
  logic [11:0] ov_len;
  logic [1:0]  ov_err_code;
  logic [15:0] ov_pkt_cnt, ov_err_cnt;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_mode;  // 0 outside packet, 1 in packet, 2 discarding
  int m_len, m_gap, m_pkts, m_errs;
  int m_olen;
  bit m_dwr, m_sop, m_eop, m_err;
  int m_data, m_code;

  psd #(.P_MAX_LEN(MAXL), .P_TIMEOUT(TOUT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .iv_data     (iv_data),
    .i_data_wr   (i_data_wr),
    .ov_data     (ov_data),
    .o_data_wr   (o_data_wr),
    .o_sop       (o_sop),
    .o_eop       (o_eop),
    .ov_len      (ov_len),
    .o_err       (o_err),
    .ov_err_code (ov_err_code),
    .ov_pkt_cnt  (ov_pkt_cnt),
    .ov_err_cnt  (ov_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_mode = 0; m_len = 0; m_gap = 0;
    m_pkts = 0; m_errs = 0; m_olen = 0;
    m_dwr = 0; m_sop = 0; m_eop = 0; m_err = 0;
    m_data = 0; m_code = 0;
  endtask

  task automatic m_error(input int code);
    m_err  = 1;
    m_code = code;
    if (m_errs < 65535) m_errs++;
  endtask

  task automatic m_step(input bit wr, input logic [8:0] d);
    bit tag;
    tag = d[8];
    m_dwr = 0; m_sop = 0; m_eop = 0; m_err = 0;
    if (wr) begin
      m_gap = 0;
      if (m_mode == 0) begin
        if (tag) begin
          m_dwr = 1; m_sop = 1; m_data = d[7:0];
          m_len = 1; m_mode = 1;
        end else m_error(1);
      end else if (m_mode == 1) begin
        if (!tag) begin
          if (m_len + 1 < MAXL) begin
            m_dwr = 1; m_data = d[7:0]; m_len++;
          end else begin
            m_error(2); m_mode = 2;
          end
        end else if (m_len + 1 > MAXL) begin
          m_error(2); m_mode = 0;
        end else begin
          m_dwr = 1; m_eop = 1; m_data = d[7:0];
          m_olen = m_len + 1; m_mode = 0;
          if (m_pkts < 65535) m_pkts++;
        end
      end else if (tag) m_mode = 0;
    end else if (m_mode != 0) begin
      m_gap++;
      if (m_gap == TOUT) begin
        if (m_mode == 1) m_error(3);
        m_mode = 0; m_gap = 0;
      end
    end
  endtask

  task automatic compare(input bit full);
    if (full) begin
      chk("dwr", o_data_wr, m_dwr);
      if (m_dwr) chk("data", ov_data, m_data);
      chk("sop", o_sop, m_sop);
      chk("eop", o_eop, m_eop);
      chk("len", ov_len, m_olen);
      chk("err", o_err, m_err);
      if (m_err) chk("code", ov_err_code, m_code);
      chk("pkt_cnt", ov_pkt_cnt, m_pkts);
    end
    chk("err_cnt", ov_err_cnt, m_errs);
  endtask

  task automatic step(input bit wr, input logic [8:0] d, input bit full = 1);
    @(negedge clk);
    i_data_wr = wr;
    iv_data   = d;
    @(posedge clk);
    m_step(wr, d);
    #1;
    compare(full);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 9'h000);
  endtask

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dwr", o_data_wr, 0);
    chk("rst_err", o_err, 0);
    chk("rst_cnt", ov_err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // normal packet then back-to-back second packet
    step(1, 9'h1AA);
    chk("t1_sop", o_sop, 1);
    step(1, 9'h011);
    step(1, 9'h022);
    step(1, 9'h1BB);
    chk("t1_eop", o_eop, 1);
    chk("t1_len", ov_len, 4);
    chk("t1_pkts", ov_pkt_cnt, 1);
    step(1, 9'h1C0);
    chk("t1_b2b_sop", o_sop, 1);
    step(1, 9'h1C1);
    chk("t1_pkts2", ov_pkt_cnt, 2);
    idle(2);

    // stray byte in idle
    step(1, 9'h055);
    chk("t2_dwr", o_data_wr, 0);
    chk("t2_code", ov_err_code, 1);
    chk("t2_errs", ov_err_cnt, 1);
    step(1, 9'h101);
    step(1, 9'h102);
    chk("t2_pkts", ov_pkt_cnt, 3);

    // overlength: limit 4 lets head + 2 bytes through
    step(1, 9'h1D0);
    step(1, 9'h0D1);
    step(1, 9'h0D2);
    step(1, 9'h0D3);
    chk("t3_err", o_err, 1);
    chk("t3_code", ov_err_code, 2);
    step(1, 9'h0D4);
    chk("t3_drop", o_data_wr, 0);
    step(1, 9'h1D5);
    chk("t3_noeop", o_eop, 0);
    chk("t3_pkts", ov_pkt_cnt, 3);

    // timeout fires exactly after TOUT idle cycles
    step(1, 9'h1E0);
    idle(TOUT - 1);
    chk("t4_early", o_err, 0);
    idle(1);
    chk("t4_to", o_err, 1);
    chk("t4_code", ov_err_code, 3);
    // a write on the last allowed cycle wins
    step(1, 9'h1E1);
    idle(TOUT - 1);
    step(1, 9'h1E2);
    chk("t4_noerr", o_err, 0);
    chk("t4_len", ov_len, 2);

    // random traffic
    for (int p = 0; p < 120; p++) begin
      int n, g;
      if ($urandom_range(0, 7) == 0) step(1, {1'b0, 8'($urandom)});
      n = $urandom_range(0, 4);
      step(1, {1'b1, 8'($urandom)});
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) idle($urandom_range(1, TOUT + 2));
        step(1, {1'b0, 8'($urandom)});
      end
      step(1, {1'b1, 8'($urandom)});
      g = $urandom_range(0, 3);
      if (g == 3) begin
        step(1, {1'b1, 8'($urandom)});
        idle($urandom_range(TOUT - 1, TOUT + 1));
      end else idle(g);
    end

    // reset mid-packet
    step(1, 9'h1F0);
    step(1, 9'h0F1);
    step(1, 9'h0F2);
    @(negedge clk);
    i_data_wr = 1'b0;
    rst = 1'b1;
    #1;
    m_reset();
    chk("t5_dwr", o_data_wr, 0);
    chk("t5_err", o_err, 0);
    chk("t5_pkts", ov_pkt_cnt, 0);
    chk("t5_errs", ov_err_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 9'h077);
    chk("t5_code", ov_err_code, 1);

    // error counter saturation
    for (int i = 0; i < 65540; i++) step(1, 9'h033, 1'b0);
    chk("t6_sat", ov_err_cnt, 16'hFFFF);
    step(1, 9'h033);
    chk("t6_hold", ov_err_cnt, 16'hFFFF);
    step(1, 9'h1AB);
    step(1, 9'h1CD);
    chk("t6_pkt", ov_pkt_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
